uart_mmio: RTL and testbench

Memory-mapped controller for the board's direct serial port (txd/rxd), attached to the CPU data-memory port alongside the RAM/CPLD-UART path. It serialises bytes written by the CPU as 8N1 frames and deserialises incoming frames into a small RX FIFO with 16x oversampling. It raises an interrupt line intended for a spare `int_i` bit of the CPU.

---
 rtl/uart_mmio.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART for the direct serial port.
// DATA / STATUS / CTRL registers, TX shifter, 16x oversampled RX feeding a
// small FIFO, and a level interrupt for pending RX data.
module uart_mmio #(
  parameter int CLK_FREQ = 11059200,
  parameter int BAUD     = 9600,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        rxd,
  output logic        txd,
  output logic        int_o
);

  localparam int DIV     = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CYC = 16 * DIV;
  localparam int DW      = $clog2(DIV);
  localparam int TW      = $clog2(BIT_CYC);
  localparam int AW      = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------- bus decode
  logic [1:0] reg_sel;
  logic       rd_acc;
  logic       wr_acc;
  logic       pop;
  logic       stat_rd;
  logic       tx_load;
  logic       tx_ready;
  logic       tx_done;

  // Only the low data byte, byte lane 0 and the word offset are meaningful.
  logic unused_bits;
  assign unused_bits = &{1'b0, sel_i[3:1], data_i[31:8], addr_i[1:0]};

  assign reg_sel = addr_i[3:2];
  assign rd_acc  = ce_i & ~we_i;
  assign wr_acc  = ce_i & we_i & sel_i[0];
  assign stat_rd = rd_acc & (reg_sel == 2'd1);

  // ---------------------------------------------------------------- baud tick
  logic [DW-1:0] baud_cnt_reg;
  logic          tick;

  assign tick = (baud_cnt_reg == DW'(DIV - 1));

  // Free-running divider producing one tick every DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       baud_cnt_reg <= '0;
    else if (tick) baud_cnt_reg <= '0;
    else           baud_cnt_reg <= baud_cnt_reg + DW'(1);
  end

  // ---------------------------------------------------------------- rxd sync
  logic rxd_meta_reg;
  logic rxd_sync_reg;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_sync_reg <= rxd_meta_reg;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]  fifo_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          fifo_empty;
  logic          fifo_full;
  logic          rx_push;
  logic          rx_overrun_set;
  logic          rx_frame_set;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (AW + 1)'(RX_DEPTH));
  assign pop        = rd_acc & (reg_sel == 2'd0) & ~fifo_empty;

  // ---------------------------------------------------------------- RX FSM
  rx_state_t rx_state_reg, rx_state_next;
  logic [3:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0] rx_bit_reg, rx_bit_next;
  logic [7:0] rx_shift_reg, rx_shift_next;

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  // RX next state: all sampling advances only on baud ticks.
  always_comb begin
    rx_state_next  = rx_state_reg;
    rx_cnt_next    = rx_cnt_reg;
    rx_bit_next    = rx_bit_reg;
    rx_shift_next  = rx_shift_reg;
    rx_push        = 1'b0;
    rx_overrun_set = 1'b0;
    rx_frame_set   = 1'b0;
    if (tick) begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (!rxd_sync_reg) begin
            rx_state_next = RX_START;
            rx_cnt_next   = '0;
          end
        end
        RX_START: begin
          // Half a bit in: a line that has gone high again was a glitch.
          if (rx_cnt_reg == 4'd7) begin
            rx_cnt_next = '0;
            rx_bit_next = '0;
            rx_state_next = rxd_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_next = rx_cnt_reg + 4'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == 4'd15) begin
            rx_cnt_next   = '0;
            rx_shift_next = {rxd_sync_reg, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
            else                    rx_bit_next   = rx_bit_reg + 3'd1;
          end else begin
            rx_cnt_next = rx_cnt_reg + 4'd1;
          end
        end
        default: begin // RX_STOP
          if (rx_cnt_reg == 4'd15) begin
            rx_state_next = RX_IDLE;
            if (!rxd_sync_reg)  rx_frame_set   = 1'b1;
            else if (fifo_full) rx_overrun_set = 1'b1;
            else                rx_push        = 1'b1;
          end else begin
            rx_cnt_next = rx_cnt_reg + 4'd1;
          end
        end
      endcase
    end
  end

  // FIFO storage: write-only port, head is read combinationally.
  always_ff @(posedge clk) begin
    if (rx_push) fifo_mem[wr_ptr_reg] <= rx_shift_reg;
  end

  // FIFO pointers and occupancy; push and pop on one edge leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (rx_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({rx_push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------- status / ctrl
  logic overrun_reg;
  logic frame_err_reg;
  logic rx_int_en_reg;

  // Sticky error flags, cleared by a STATUS read; a new error on the same edge wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (rx_overrun_set) overrun_reg <= 1'b1;
      else if (stat_rd)   overrun_reg <= 1'b0;
      if (rx_frame_set)   frame_err_reg <= 1'b1;
      else if (stat_rd)   frame_err_reg <= 1'b0;
    end
  end

  // CTRL register holding the RX interrupt enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              rx_int_en_reg <= 1'b0;
    else if (wr_acc && reg_sel == 2'd2)   rx_int_en_reg <= data_i[0];
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t tx_state_reg, tx_state_next;
  logic [TW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          txd_reg, txd_next;

  assign tx_ready = (tx_state_reg == TX_IDLE);
  assign tx_done  = (tx_state_reg == TX_STOP) && (tx_cnt_reg == TW'(BIT_CYC - 1));
  // The edge that ends the stop bit may already take the next byte.
  assign tx_load  = wr_acc & (reg_sel == 2'd0) & (tx_ready | tx_done);

  // TX state register; txd idles high and is forced high by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
    end
  end

  // TX next state: each bit is held for BIT_CYC cycles.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    txd_next      = txd_reg;
    if (tx_load) begin
      tx_state_next = TX_START;
      tx_cnt_next   = '0;
      tx_shift_next = data_i[7:0];
      txd_next      = 1'b0;
    end else if (tx_state_reg != TX_IDLE) begin
      if (tx_cnt_reg == TW'(BIT_CYC - 1)) begin
        tx_cnt_next = '0;
        case (tx_state_reg)
          TX_START: begin
            tx_state_next = TX_DATA;
            tx_bit_next   = '0;
            txd_next      = tx_shift_reg[0];
          end
          TX_DATA: begin
            if (tx_bit_reg == 3'd7) begin
              tx_state_next = TX_STOP;
              txd_next      = 1'b1;
            end else begin
              tx_bit_next   = tx_bit_reg + 3'd1;
              tx_shift_next = {1'b0, tx_shift_reg[7:1]};
              txd_next      = tx_shift_reg[1];
            end
          end
          default: tx_state_next = TX_IDLE; // TX_STOP
        endcase
      end else begin
        tx_cnt_next = tx_cnt_reg + TW'(1);
      end
    end
  end

  assign txd = txd_reg;

  // ---------------------------------------------------------------- read mux
  // Zero-latency register read; any pop lands on the access edge.
  always_comb begin
    data_o = '0;
    case (reg_sel)
      2'd0:    data_o = fifo_empty ? 32'd0 : {24'd0, fifo_mem[rd_ptr_reg]};
      2'd1:    data_o = {28'd0, frame_err_reg, overrun_reg, tx_ready, ~fifo_empty};
      2'd2:    data_o = {31'd0, rx_int_en_reg};
      default: data_o = '0;
    endcase
  end

  assign int_o = rx_int_en_reg & ~fifo_empty;

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: bus reads and TX frames are queued as
// expectations by the stimulus and consumed by independent monitors.
module tb_uart_mmio;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, we_i;
  logic [3:0]  addr_i, sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        rxd, txd, int_o;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct { string name; logic [31:0] val; } rd_exp_t;
  rd_exp_t    exp_rd[$];
  logic [7:0] exp_tx[$];

  uart_mmio #(.CLK_FREQ(640), .BAUD(10), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .rxd(rxd),
    .txd(txd), .int_o(int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s = 0x%08h", name, act);
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // All bus tasks start and end at posedge+1.
  task automatic bus_read(input logic [3:0] a, input logic [31:0] e, input string name);
    rd_exp_t x;
    x.name = name; x.val = e;
    exp_rd.push_back(x);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a; sel_i = 4'hF;
    @(posedge clk); #1;
    ce_i = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; sel_i = 4'h1; data_i = d;
    @(posedge clk); #1;
    ce_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] lv;
    lv = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = lv[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    $display("rx frame 0x%02h stop=%0d sent", b, stop);
  endtask

  // Read monitor: every read access is compared against the queued expectation.
  always @(negedge clk) begin
    if (ce_i && !we_i && !rst) begin
      if (exp_rd.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got 0x%08h, expected no access", data_o);
      end else begin
        rd_exp_t x;
        x = exp_rd.pop_front();
        chk(x.name, data_o, x.val);
      end
    end
  end

  // TX monitor: on a start bit, check every cycle of the frame against the queued byte.
  initial begin : tx_mon
    logic [9:0] lv;
    logic [7:0] b;
    int bad;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        if (exp_tx.size() == 0) begin
          n_total++;
          $display("FAIL tx_unexpected: got start bit, expected idle line");
          repeat (10 * BIT) @(negedge clk);
        end else begin
          b = exp_tx.pop_front();
          lv = {1'b1, b, 1'b0};
          bad = 0;
          aborted = 0;
          for (int k = 0; k < 10 * BIT; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin aborted = 1; break; end
            if (txd !== lv[k / BIT]) bad++;
          end
          if (aborted) begin
            $display("tx frame 0x%02h aborted by reset", b);
          end else begin
            n_total++;
            if (bad == 0) begin
              n_pass++;
              $display("ok   tx_frame 0x%02h", b);
            end else begin
              $display("FAIL tx_frame 0x%02h: got %0d wrong cycles, expected 0", b, bad);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int i;
    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0; rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset defaults
    addr_i = 4'h4;
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_int", {31'd0, int_o}, 32'd0);
    chk("rst_status", data_o, 32'h2);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cyc(2);
    bus_read(4'h0, 32'h0, "rst_data_empty");
    bus_read(4'h4, 32'h2, "rst_status_after_pop");

    // TX 0xA5 with a dropped mid-frame write
    exp_tx.push_back(8'hA5);
    bus_write(4'h0, 32'hA5);                 // now in cycle 0 of the frame
    bus_read(4'h4, 32'h0, "tx_busy_status"); // cycle 0, now in cycle 1
    wait_cyc(5 * BIT - 1);                   // cycle 5*BIT
    bus_write(4'h0, 32'h5A);                 // dropped
    wait_cyc(10 * BIT - 1 - (5 * BIT + 1));  // cycle 10*BIT-1
    bus_read(4'h4, 32'h0, "tx_last_busy_cycle");
    bus_read(4'h4, 32'h2, "tx_ready_again");
    wait_cyc(2 * BIT);

    // RX 0x3C with interrupt
    send_rx(8'h3C, 1'b1);
    bus_read(4'h4, 32'h3, "rx_status_avail");
    chk("rx_int_disabled", {31'd0, int_o}, 32'd0);
    bus_write(4'h8, 32'h1);
    chk("rx_int_enabled", {31'd0, int_o}, 32'd1);
    bus_read(4'h8, 32'h1, "ctrl_read");
    bus_read(4'hC, 32'h0, "reg3_read");
    bus_read(4'h0, 32'h3C, "rx_data_3c");
    chk("rx_int_after_pop", {31'd0, int_o}, 32'd0);

    // Overrun: five back-to-back frames into a 4-deep FIFO
    for (i = 1; i <= 5; i++) send_rx(i[7:0], 1'b1);
    bus_read(4'h4, 32'h7, "ovr_status");
    bus_read(4'h4, 32'h3, "ovr_status_cleared");
    for (i = 1; i <= 4; i++) bus_read(4'h0, i, "ovr_data");
    bus_read(4'h0, 32'h0, "ovr_data_empty");
    bus_read(4'h4, 32'h2, "ovr_status_final");

    // Frame error
    send_rx(8'h5A, 1'b0);
    wait_cyc(BIT);
    bus_read(4'h4, 32'hA, "ferr_status");
    bus_read(4'h4, 32'h2, "ferr_status_cleared");
    bus_read(4'h0, 32'h0, "ferr_fifo_empty");

    // Three-tick glitch
    rxd = 1'b0;
    wait_cyc(3 * DIV);
    rxd = 1'b1;
    wait_cyc(2 * BIT);
    bus_read(4'h4, 32'h2, "glitch_status");
    bus_read(4'h0, 32'h0, "glitch_fifo_empty");

    // Pop on the same edge as a push, FIFO holding two entries
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    fork
      send_rx(8'h33, 1'b1);
      begin
        int n;
        n = 0;
        while (dut.rx_push !== 1'b1 && n < 12 * BIT) begin
          @(posedge clk); #1;
          n++;
        end
        if (n >= 12 * BIT) begin
          n_total++;
          $display("FAIL sim_push_wait: got no push, expected push within %0d cycles", 12 * BIT);
        end else begin
          bus_read(4'h0, 32'h11, "sim_pop_old_head");
        end
      end
    join
    bus_read(4'h0, 32'h22, "sim_data_2");
    bus_read(4'h0, 32'h33, "sim_data_3");
    bus_read(4'h0, 32'h0, "sim_data_empty");

    // Reset mid-TX
    exp_tx.push_back(8'hC3);
    bus_write(4'h0, 32'hC3);
    wait_cyc(3 * BIT);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_txd", {31'd0, txd}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    wait_cyc(2);
    bus_read(4'h4, 32'h2, "rst_mid_tx_status");
    bus_read(4'h8, 32'h0, "rst_mid_tx_ctrl");
    wait_cyc(2 * BIT);

    chk("rd_queue_drained", exp_rd.size(), 32'd0);
    chk("tx_queue_drained", exp_tx.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
